// File: rtl/jt1942_snd_mixer.sv
// jt1942_snd_mixer: N-channel sound mixer with CPU-writable per-channel gain.
// A single multiply-accumulate is time-shared across the channels, one channel
// per clock. Each sample is then scaled down by GAIN_FRAC and saturated to OUT_W bits.
// Optional feature macro: JTSND_MIX_PEAK_EN adds a peak-hold register on snd.
module jt1942_snd_mixer #(
  parameter  int CH        = 4,
  parameter  int IN_W      = 10,
  parameter  int GAIN_W    = 8,
  parameter  int GAIN_FRAC = 4,
  parameter  int OUT_W     = 9,
  localparam int AW        = (CH > 1) ? $clog2(CH) : 1,
  localparam int ACC_W     = IN_W + GAIN_W + AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic [CH*IN_W-1:0]   ch_in,
  input  logic                 gain_we,
  input  logic [AW-1:0]        gain_addr,
  input  logic [GAIN_W-1:0]    gain_din,
  output logic [OUT_W-1:0]     snd,
  output logic                 sample,
  output logic                 clip,
  output logic                 overrun,
  output logic [OUT_W-1:0]     peak,
  input  logic                 peak_clr
);

  localparam int                PW    = IN_W + GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_FRAC);
  localparam logic [AW-1:0]     LAST  = AW'(CH - 1);
  localparam logic [ACC_W-1:0]  MAXV  = ACC_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [GAIN_W-1:0]  r_gain    [CH];
  logic [GAIN_W-1:0]  r_sh_gain [CH];
  logic [IN_W-1:0]    r_sh_in   [CH];
  logic [AW-1:0]      r_idx;
  logic [ACC_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_snd;
  logic               r_sample;
  logic               r_clip;
  logic               r_overrun;

  logic [PW-1:0]      w_prod;
  logic [ACC_W-1:0]   w_r;
  logic               w_sat;
  logic [OUT_W-1:0]   w_snd_new;

  // Shared multiplier and the scale/saturate stage feeding snd
  always_comb begin
    w_prod    = PW'(r_sh_in[r_idx]) * PW'(r_sh_gain[r_idx]);
    w_r       = r_acc >> GAIN_FRAC;
    w_sat     = (w_r > MAXV);
    w_snd_new = w_sat ? '1 : w_r[OUT_W-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: IDLE -> ACC (CH clocks) -> OUT -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cen) w_next = ACC;
      ACC:     if (r_idx == LAST) w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: live gain bank, shadow capture, accumulate and output update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_gain[i]    <= UNITY;
        r_sh_gain[i] <= UNITY;
        r_sh_in[i]   <= '0;
      end
      r_idx     <= '0;
      r_acc     <= '0;
      r_snd     <= '0;
      r_sample  <= 1'b0;
      r_clip    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sample  <= 1'b0;
      r_overrun <= 1'b0;
      // Out-of-range addresses match no entry and are dropped
      for (int unsigned i = 0; i < CH; i++) begin
        if (gain_we && gain_addr == AW'(i)) r_gain[i] <= gain_din;
      end
      case (r_state)
        IDLE: begin
          if (cen) begin
            for (int unsigned i = 0; i < CH; i++) begin
              r_sh_in[i]   <= ch_in[i*IN_W +: IN_W];
              r_sh_gain[i] <= r_gain[i];
            end
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ACC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_idx <= r_idx + 1'b1;
          if (cen) r_overrun <= 1'b1;
        end
        OUT: begin
          r_snd    <= w_snd_new;
          r_clip   <= w_sat;
          r_sample <= 1'b1;
          if (cen) r_overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign snd     = r_snd;
  assign sample  = r_sample;
  assign clip    = r_clip;
  assign overrun = r_overrun;

`ifdef JTSND_MIX_PEAK_EN
  logic [OUT_W-1:0] r_peak;

  // Peak hold; a clear coinciding with OUT restarts from the new sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak <= '0;
    end else if (r_state == OUT) begin
      if (peak_clr || w_snd_new > r_peak) r_peak <= w_snd_new;
    end else if (peak_clr) begin
      r_peak <= '0;
    end
  end

  assign peak = r_peak;
`else
  logic w_unused_peak_clr;

  assign w_unused_peak_clr = peak_clr;
  assign peak              = '0;
`endif

endmodule

// File: tb/tb_jt1942_snd_mixer.sv
// Directed, table-driven bench for jt1942_snd_mixer (CH=4 main instance,
// CH=3 instance for the out-of-range gain address case).
module tb_jt1942_snd_mixer;

`ifdef JTSND_MIX_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen, gain_we, peak_clr;
  logic [39:0] ch_in;
  logic [1:0]  gain_addr;
  logic [7:0]  gain_din;
  logic [8:0]  snd, peak;
  logic        sample, clip, overrun;

  logic        cen3, gain_we3;
  logic [29:0] ch_in3;
  logic [1:0]  gain_addr3;
  logic [7:0]  gain_din3;
  logic [8:0]  snd3, peak3;
  logic        sample3, clip3, overrun3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jt1942_snd_mixer #(.CH(4), .IN_W(10), .GAIN_W(8), .GAIN_FRAC(4), .OUT_W(9)) u_dut (
    .clk(clk), .rst(rst), .cen(cen), .ch_in(ch_in), .gain_we(gain_we),
    .gain_addr(gain_addr), .gain_din(gain_din), .snd(snd), .sample(sample),
    .clip(clip), .overrun(overrun), .peak(peak), .peak_clr(peak_clr)
  );

  jt1942_snd_mixer #(.CH(3), .IN_W(10), .GAIN_W(8), .GAIN_FRAC(4), .OUT_W(9)) u_dut3 (
    .clk(clk), .rst(rst), .cen(cen3), .ch_in(ch_in3), .gain_we(gain_we3),
    .gain_addr(gain_addr3), .gain_din(gain_din3), .snd(snd3), .sample(sample3),
    .clip(clip3), .overrun(overrun3), .peak(peak3), .peak_clr(1'b0)
  );

  typedef struct {
    bit wr;
    int in_v [4];
    int g    [4];
    int exp_snd;
    int exp_clip;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d);
    ch_in = {10'(d), 10'(c), 10'(b), 10'(a)};
  endtask

  task automatic wr_gain(input int addr, input int v);
    @(negedge clk);
    gain_we   = 1'b1;
    gain_addr = 2'(addr);
    gain_din  = 8'(v);
    @(negedge clk);
    gain_we   = 1'b0;
  endtask

  // Returns the negedge count since the cen cycle at which sample was seen
  task automatic wait_sample(input int start, output int lat);
    lat = start;
    while (sample !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pulse_cen();
    @(negedge clk);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
  endtask

  task automatic mix_expect(input string name, input int exp_snd);
    int lat;
    pulse_cen();
    wait_sample(1, lat);
    chk({name, "_lat"}, 32'(lat), 32'd6);
    chk({name, "_snd"}, 32'(snd), 32'(exp_snd));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, nsamp, novr, s;

    vt[0] = '{0, '{100, 200, 50, 25},   '{16, 16, 16, 16},  375, 0};
    vt[1] = '{1, '{100, 200, 50, 25},   '{32, 0, 16, 8},    262, 0};
    vt[2] = '{0, '{1023, 1023, 1023, 1023}, '{32, 0, 16, 8}, 511, 1};
    vt[3] = '{1, '{0, 0, 0, 0},         '{16, 16, 16, 16},  0,   0};
    vt[4] = '{0, '{511, 0, 0, 0},       '{16, 16, 16, 16},  511, 0};
    vt[5] = '{0, '{512, 0, 0, 0},       '{16, 16, 16, 16},  511, 1};
    vt[6] = '{1, '{1, 1, 1, 1},         '{17, 17, 17, 17},  4,   0};
    vt[7] = '{1, '{1023, 1023, 1023, 1023}, '{255, 255, 255, 255}, 511, 1};
    vt[8] = '{1, '{1, 2, 3, 4},         '{16, 16, 16, 16},  10,  0};
    vt[9] = '{0, '{0, 0, 0, 200},       '{16, 16, 16, 16},  200, 0};

    cen = 1'b0; gain_we = 1'b0; gain_addr = '0; gain_din = '0; peak_clr = 1'b0;
    ch_in = '0;
    cen3 = 1'b0; gain_we3 = 1'b0; gain_addr3 = '0; gain_din3 = '0; ch_in3 = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_snd", 32'(snd), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_clip", 32'(clip), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_peak", 32'(peak), 0);

    // Table: vector 0 relies on reset-time unity gains
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr)
        for (int c = 0; c < 4; c++) wr_gain(c, vt[i].g[c]);
      set_in(vt[i].in_v[0], vt[i].in_v[1], vt[i].in_v[2], vt[i].in_v[3]);
      pulse_cen();
      wait_sample(1, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd6);
      chk($sformatf("v%0d_snd", i), 32'(snd), 32'(vt[i].exp_snd));
      chk($sformatf("v%0d_clip", i), 32'(clip), 32'(vt[i].exp_clip));
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), 32'(sample), 0);
    end

    // Overrun: second cen two clocks after the first; inputs change after capture
    set_in(100, 200, 50, 25);
    @(negedge clk); cen = 1'b1;
    @(negedge clk); cen = 1'b0; set_in(1, 1, 1, 1);
    @(negedge clk); cen = 1'b1;
    @(negedge clk); cen = 1'b0;
    chk("ovr_pulse", 32'(overrun), 1);
    nsamp = 0; novr = 0; s = -1;
    repeat (10) begin
      @(negedge clk);
      if (sample) begin nsamp++; s = int'(snd); end
      if (overrun) novr++;
    end
    chk("ovr_nsamp", 32'(nsamp), 1);
    chk("ovr_extra", 32'(novr), 0);
    chk("ovr_snd", 32'(s), 375);

    // Gain write during ACC only affects the following sample
    set_in(100, 200, 50, 25);
    @(negedge clk); cen = 1'b1;
    @(negedge clk); cen = 1'b0;
    @(negedge clk); gain_we = 1'b1; gain_addr = 2'd0; gain_din = 8'h20;
    @(negedge clk); gain_we = 1'b0;
    wait_sample(3, lat);
    chk("gacc_lat", 32'(lat), 6);
    chk("gacc_snd", 32'(snd), 375);
    // Write coinciding with the capturing cen is not seen by that sample
    @(negedge clk); cen = 1'b1; gain_we = 1'b1; gain_addr = 2'd1; gain_din = 8'h00;
    @(negedge clk); cen = 1'b0; gain_we = 1'b0;
    wait_sample(1, lat);
    chk("gcen_snd", 32'(snd), 475);
    mix_expect("gnext", 275);

    // Reset at ACC idx=2 aborts the mix and restores unity gains
    @(negedge clk); cen = 1'b1;
    @(negedge clk); cen = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    nsamp = 0;
    repeat (8) begin
      @(negedge clk);
      if (sample) nsamp++;
    end
    chk("rmid_nsamp", 32'(nsamp), 0);
    chk("rmid_snd", 32'(snd), 0);
    chk("rmid_clip", 32'(clip), 0);
    mix_expect("rmid_next", 375);

    // Peak hold sequence (tied to zero when the feature is not built)
    set_in(300, 0, 0, 0); mix_expect("pk300", 300);
    set_in(120, 0, 0, 0); mix_expect("pk120", 120);
    set_in(400, 0, 0, 0); mix_expect("pk400", 400);
    chk("peak_max", 32'(peak), PEAK ? 400 : 0);
    @(negedge clk); peak_clr = 1'b1;
    @(negedge clk); peak_clr = 1'b0;
    chk("peak_clr", 32'(peak), 0);
    set_in(50, 0, 0, 0); mix_expect("pk50", 50);
    chk("peak_after", 32'(peak), PEAK ? 50 : 0);

    // CH=3 instance: address 3 is out of range and must be dropped
    @(negedge clk); gain_we3 = 1'b1; gain_addr3 = 2'd3; gain_din3 = 8'h00;
    @(negedge clk); gain_we3 = 1'b0;
    ch_in3 = {10'd16, 10'd16, 10'd16};
    @(negedge clk); cen3 = 1'b1;
    @(negedge clk); cen3 = 1'b0;
    lat = 1;
    while (sample3 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("c3_lat", 32'(lat), 5);
    chk("c3_snd", 32'(snd3), 48);
    @(negedge clk); gain_we3 = 1'b1; gain_addr3 = 2'd2; gain_din3 = 8'h20;
    @(negedge clk); gain_we3 = 1'b0;
    @(negedge clk); cen3 = 1'b1;
    @(negedge clk); cen3 = 1'b0;
    lat = 1;
    while (sample3 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("c3_g2_snd", 32'(snd3), 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
